// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
//
// Purpose: bundles the byte-stream handshake and the instruction-memory write
// port used by imem_loader.
//
// Signals:
//   byte_valid  source -> loader  byte_data holds a valid byte
//   byte_data   source -> loader  stream byte
//   byte_ready  loader -> source  loader accepts a byte this cycle
//   wr_en       loader -> memory  write strobe
//   wr_addr     loader -> memory  word-aligned byte address
//   wr_data     loader -> memory  word to write
//
// Modports:
//   slave  - the loader itself
//   master - the environment (byte source plus memory write port)
// -----------------------------------------------------------------------------
interface imem_loader_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 12
);
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [WIDTH-1:0]      wr_data;

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, wr_en, wr_addr, wr_data
    );

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Purpose: fills instruction memory from a framed little-endian byte stream and
// holds the core in reset until the image is complete.
//   Frame: 4 length bytes (N words, LE), then N words of 4 bytes each (LE).
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-low reset
//   start        one-cycle load request (honoured in IDLE, DONE, ERR)
//   bus          imem_loader_if.slave: byte handshake + memory write port
//   cpu_hold     keep the core in reset
//   done         image loaded successfully
//   error        load aborted
//   words_loaded words written in the current load
//
// Optional build macro:
//   IMEM_LOADER_CHECKSUM_EN - after the last word, receive 4 more LE bytes that
//   must equal the mod-2^32 sum of all data words (match -> DONE, else ERR).
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    imem_loader_if.slave          bus,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-2:0] words_loaded
);
    localparam int CNT_W = ADDR_WIDTH - 1;
    localparam logic [WIDTH-1:0] MAX_WORDS = WIDTH'(1) << (ADDR_WIDTH - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
        , S_CHECK
`endif
    } state_t;

    state_t                state_q;
    logic [1:0]            byte_idx_q;
    logic [WIDTH-1:0]      asm_q;
    logic [CNT_W-1:0]      len_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  byte_ready_q;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [WIDTH-1:0]      wr_data_q;
    logic                  cpu_hold_q;
    logic                  done_q;
    logic                  error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [WIDTH-1:0]      sum_q;
`endif

    logic                  accept;
    logic                  last_byte;
    logic [WIDTH-1:0]      asm_d;
    logic [CNT_W-1:0]      cnt_d;

    // byte_ready_q is high exactly in LEN/DATA/CHECK, so it doubles as the
    // "consuming state" qualifier for the handshake.
    assign accept    = bus.byte_valid && byte_ready_q;
    assign last_byte = (byte_idx_q == 2'd3);
    // Shift right so the first byte of a word ends up in bits [7:0].
    assign asm_d     = {bus.byte_data, asm_q[WIDTH-1:8]};
    assign cnt_d     = cnt_q + CNT_W'(1);

    // NOTE: all state lives in this one clocked block and is updated with
    // non-blocking assignments, so every right-hand side sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            byte_idx_q   <= 2'd0;
            asm_q        <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            byte_ready_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state_q      <= S_LEN;
                        byte_ready_q <= 1'b1;
                        cpu_hold_q   <= 1'b1;
                        done_q       <= 1'b0;
                        error_q      <= 1'b0;
                        byte_idx_q   <= 2'd0;
                        asm_q        <= '0;
                        cnt_q        <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_q        <= '0;
`endif
                    end
                end

                S_LEN: begin
                    if (accept) begin
                        asm_q      <= asm_d;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (last_byte) begin
                            if (asm_d == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state_q      <= S_CHECK;
`else
                                state_q      <= S_DONE;
                                byte_ready_q <= 1'b0;
                                done_q       <= 1'b1;
                                cpu_hold_q   <= 1'b0;
`endif
                            end else if (asm_d > MAX_WORDS) begin
                                state_q      <= S_ERR;
                                byte_ready_q <= 1'b0;
                                error_q      <= 1'b1;
                            end else begin
                                state_q <= S_DATA;
                                len_q   <= asm_d[CNT_W-1:0];
                            end
                        end
                    end
                end

                S_DATA: begin
                    if (accept) begin
                        asm_q      <= asm_d;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (last_byte) begin
                            state_q      <= S_WRITE;
                            byte_ready_q <= 1'b0;
                            wr_en_q      <= 1'b1;
                            // cnt_q < N <= capacity, so its top bit is zero here.
                            wr_addr_q    <= {cnt_q[CNT_W-2:0], 2'b00};
                            wr_data_q    <= asm_d;
                        end
                    end
                end

                S_WRITE: begin
                    cnt_q <= cnt_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_q <= sum_q + wr_data_q;
`endif
                    if (cnt_d == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_q      <= S_CHECK;
                        byte_ready_q <= 1'b1;
`else
                        state_q      <= S_DONE;
                        done_q       <= 1'b1;
                        cpu_hold_q   <= 1'b0;
`endif
                    end else begin
                        state_q      <= S_DATA;
                        byte_ready_q <= 1'b1;
                    end
                end

`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (accept) begin
                        asm_q      <= asm_d;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (last_byte) begin
                            byte_ready_q <= 1'b0;
                            if (asm_d == sum_q) begin
                                state_q    <= S_DONE;
                                done_q     <= 1'b1;
                                cpu_hold_q <= 1'b0;
                            end else begin
                                state_q <= S_ERR;
                                error_q <= 1'b1;
                            end
                        end
                    end
                end
`endif

                default: begin
                    state_q      <= S_IDLE;
                    byte_ready_q <= 1'b0;
                    cpu_hold_q   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign cpu_hold       = cpu_hold_q;
    assign done           = done_q;
    assign error          = error_q;
    assign words_loaded   = cnt_q;
endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Directed bench for imem_loader (ADDR_WIDTH = 12). Expected memory writes are
// queued when the corresponding word is sent; a monitor pops and compares on
// every wr_en cycle. Builds with or without IMEM_LOADER_CHECKSUM_EN.
// -----------------------------------------------------------------------------
module tb_imem_loader;
    localparam int WIDTH      = 32;
    localparam int ADDR_WIDTH = 12;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int DONE_LAT = 0;
`else
    localparam int DONE_LAT = 1;
`endif

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [WIDTH-1:0]      data;
    } wr_t;

    logic                  clk;
    logic                  rst;
    logic                  start;
    logic                  cpu_hold;
    logic                  done;
    logic                  error;
    logic [ADDR_WIDTH-2:0] words_loaded;

    int checks = 0;
    int errors = 0;

    wr_t         sb[$];
    logic [31:0] frame[$];
    logic        prev_wr_en = 1'b0;

    imem_loader_if #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

    imem_loader #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bus          (bus),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        wr_t exp_wr;
        if (bus.wr_en === 1'b1) begin
            check("wr_en_single_cycle", 32'(prev_wr_en), 32'd0);
            if (sb.size() == 0) begin
                check("write_expected", 32'(sb.size()), 32'd1);
            end else begin
                exp_wr = sb.pop_front();
                check("wr_addr", 32'(bus.wr_addr), 32'(exp_wr.addr));
                check("wr_data", bus.wr_data, exp_wr.data);
            end
        end
        prev_wr_en = (bus.wr_en === 1'b1);
    end

    // All driving tasks start and end at a falling edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int budget;
        for (int i = 0; i < gap; i++) begin
            bus.byte_valid = 1'b0;
            bus.byte_data  = 8'($urandom);
            @(negedge clk);
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        budget = 0;
        while (!bus.byte_ready && budget < 64) begin
            @(negedge clk);
            budget++;
        end
        if (!bus.byte_ready) check("byte_accepted", 32'(bus.byte_ready), 32'd1);
        else @(negedge clk);
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'($urandom);
    endtask

    task automatic send_word(input logic [31:0] w, input int gapmax);
        for (int k = 0; k < 4; k++)
            send_byte(w[8*k +: 8], (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0);
    endtask

    // Sends the length plus every word in 'frame'; expected writes are queued
    // as each word goes out. With the checksum build, the sum (+bad) follows.
    task automatic send_frame(input int gapmax, input logic [31:0] bad);
        logic [31:0] sum;
        sum = 32'd0;
        send_word(32'(frame.size()), gapmax);
        for (int i = 0; i < frame.size(); i++) begin
            sb.push_back('{addr: ADDR_WIDTH'(i * 4), data: frame[i]});
            sum = sum + frame[i];
            send_word(frame[i], gapmax);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(sum + bad, gapmax);
`else
        if (bad != 32'd0) sum = sum + bad;
`endif
    endtask

    task automatic start_load();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(output int lat);
        lat = 0;
        while (!done && !error && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!done && !error) check("load_ended", 32'(done | error), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        rst            = 1'b0;
        start          = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;

        // ---------------- reset values ----------------
        repeat (3) @(negedge clk);
        check("rst_cpu_hold",   32'(cpu_hold),       32'd1);
        check("rst_done",       32'(done),           32'd0);
        check("rst_error",      32'(error),          32'd0);
        check("rst_wr_en",      32'(bus.wr_en),      32'd0);
        check("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
        check("rst_words",      32'(words_loaded),   32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_byte_ready", 32'(bus.byte_ready), 32'd0);
        check("idle_cpu_hold",   32'(cpu_hold),       32'd1);

        // ---------------- single word, back to back ----------------
        start_load();
        check("len_byte_ready", 32'(bus.byte_ready), 32'd1);
        frame = '{32'h0050_0093};
        send_frame(0, 32'd0);
        wait_end(lat);
        check("single_latency", 32'(lat),          32'(DONE_LAT));
        check("single_done",    32'(done),         32'd1);
        check("single_hold",    32'(cpu_hold),     32'd0);
        check("single_words",   32'(words_loaded), 32'd1);
        check("single_pending", 32'(sb.size()),    32'd0);

        // ---------------- three words with source gaps ----------------
        start_load();
        check("restart_done",  32'(done),         32'd0);
        check("restart_hold",  32'(cpu_hold),     32'd1);
        check("restart_words", 32'(words_loaded), 32'd0);
        frame = '{32'h0000_0013, 32'hDEAD_BEEF, 32'h1234_5678};
        send_frame(3, 32'd0);
        wait_end(lat);
        check("three_done",    32'(done),         32'd1);
        check("three_error",   32'(error),        32'd0);
        check("three_words",   32'(words_loaded), 32'd3);
        check("three_pending", 32'(sb.size()),    32'd0);

        // ---------------- N = 1025 (one past capacity) ----------------
        start_load();
        send_word(32'd1025, 0);
        wait_end(lat);
        check("n1025_error", 32'(error),          32'd1);
        check("n1025_done",  32'(done),           32'd0);
        check("n1025_hold",  32'(cpu_hold),       32'd1);
        check("n1025_ready", 32'(bus.byte_ready), 32'd0);

        start_load();
        check("err_restart_error", 32'(error), 32'd0);
        send_word(32'h0001_0000, 0);
        wait_end(lat);
        check("n65536_error", 32'(error), 32'd1);

        // ---------------- N = 0 ----------------
        start_load();
        frame = {};
        send_frame(0, 32'd0);
        wait_end(lat);
        check("n0_done",  32'(done),         32'd1);
        check("n0_error", 32'(error),        32'd0);
        check("n0_words", 32'(words_loaded), 32'd0);

        // ---------------- reset in the middle of a word ----------------
        start_load();
        send_word(32'd1, 0);
        send_byte(8'h93, 0);
        send_byte(8'h00, 0);
        #2 rst = 1'b0;
        #1;
        check("midrst_ready",   32'(bus.byte_ready), 32'd0);
        check("midrst_hold",    32'(cpu_hold),       32'd1);
        check("midrst_wr_en",   32'(bus.wr_en),      32'd0);
        check("midrst_wr_addr", 32'(bus.wr_addr),    32'd0);
        check("midrst_wr_data", bus.wr_data,         32'd0);
        check("midrst_done",    32'(done),           32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        start_load();
        frame = '{32'h0050_0093};
        send_frame(0, 32'd0);
        wait_end(lat);
        check("reload_done",    32'(done),         32'd1);
        check("reload_words",   32'(words_loaded), 32'd1);
        check("reload_pending", 32'(sb.size()),    32'd0);

        // ---------------- words 1 and 2 ----------------
        start_load();
        frame = '{32'h0000_0001, 32'h0000_0002};
        send_frame(0, 32'd0);
        wait_end(lat);
        check("two_done",    32'(done),      32'd1);
        check("two_error",   32'(error),     32'd0);
        check("two_pending", 32'(sb.size()), 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        start_load();
        send_frame(0, 32'd1);
        wait_end(lat);
        check("badsum_error",   32'(error),        32'd1);
        check("badsum_done",    32'(done),         32'd0);
        check("badsum_words",   32'(words_loaded), 32'd2);
        check("badsum_pending", 32'(sb.size()),    32'd0);
`endif

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
